// File: rtl/seq_divider_pkg.sv
// Shared types for the seq_divider restoring divider: FSM state encoding and counter sizing.
// Optional signed mode is enabled in the top by defining JDIV_SIGNED_EN.
package seq_divider_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Bits needed to count 0..n inclusive.
   function automatic int count_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/seq_divider_jsub.sv
// Ripple subtractor jsubN: a chain of jadd full adders computing a - b as a + ~b + 1.
// o_cout=1 means no borrow (a >= b as unsigned).
module jadd (
   input  logic i_a,
   input  logic i_b,
   input  logic i_cin,
   output logic o_sum,
   output logic o_cout
);
   assign o_sum  = i_a ^ i_b ^ i_cin;
   assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));
endmodule

module jsubN #(
   parameter int W = 9
) (
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   output logic [W-1:0] o_diff,
   output logic         o_cout
);
   logic [W:0] w_carry;

   assign w_carry[0] = 1'b1;

   for (genvar g = 0; g < W; g++) begin : g_bit
      jadd u_add (
         .i_a   (i_a[g]),
         .i_b   (~i_b[g]),
         .i_cin (w_carry[g]),
         .o_sum (o_diff[g]),
         .o_cout(w_carry[g+1])
      );
   end

   assign o_cout = w_carry[W];
endmodule

// File: rtl/seq_divider.sv
// Iterative restoring divider, one quotient bit per clock; DIV/MOD unit beside the ALU.
// Define JDIV_SIGNED_EN to add the wsigned port for two's complement operands.
module seq_divider
   import seq_divider_pkg::*;
#(
   parameter int N = 8
) (
   input  logic         wclk,
   input  logic         wrst_n,
   input  logic         wstart,
`ifdef JDIV_SIGNED_EN
   input  logic         wsigned,
`endif
   input  logic [N-1:0] bdividend,
   input  logic [N-1:0] bdivisor,
   output logic         wbusy,
   output logic         wdone,
   output logic [N-1:0] bquot,
   output logic [N-1:0] brem,
   output logic         wdivz
);

   localparam int CW = count_width(N);

   state_t          r_state;
   state_t          w_state_nxt;
   logic [CW-1:0]   r_count;
   logic [N:0]      r_p;
   logic [N-1:0]    r_q;
   logic [N-1:0]    r_div;
   logic [N-1:0]    r_quot;
   logic [N-1:0]    r_rem;
   logic            r_divz;
   logic            r_neg_q;
   logic            r_neg_r;

   logic [N:0]      w_p_sh;
   logic [N:0]      w_t;
   logic            w_cout;
   logic            w_borrow;
   logic            w_divz_in;
   logic            w_dvd_neg;
   logic            w_dvs_neg;
   logic [N-1:0]    w_dvd_mag;
   logic [N-1:0]    w_dvs_mag;
   logic [N-1:0]    w_quot_fin;
   logic [N-1:0]    w_rem_fin;
   logic            w_unused_p_msb;

`ifdef JDIV_SIGNED_EN
   assign w_dvd_neg = wsigned & bdividend[N-1];
   assign w_dvs_neg = wsigned & bdivisor[N-1];
`else
   assign w_dvd_neg = 1'b0;
   assign w_dvs_neg = 1'b0;
`endif

   // The most negative value maps to 2^(N-1), which still fits the unsigned core.
   assign w_dvd_mag = w_dvd_neg ? -bdividend : bdividend;
   assign w_dvs_mag = w_dvs_neg ? -bdivisor  : bdivisor;
   assign w_divz_in = (bdivisor == '0);

   assign w_p_sh   = {r_p[N-1:0], r_q[N-1]};
   assign w_borrow = ~w_cout;

   jsubN #(.W(N + 1)) u_sub (
      .i_a   (w_p_sh),
      .i_b   ({1'b0, r_div}),
      .o_diff(w_t),
      .o_cout(w_cout)
   );

   // After every restore step P < divisor, so the top bit of P is always zero.
   assign w_unused_p_msb = r_p[N];

   assign w_quot_fin = r_neg_q ? -r_q : r_q;
   assign w_rem_fin  = r_neg_r ? -r_p[N-1:0] : r_p[N-1:0];

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) r_state <= ST_IDLE;
      else         r_state <= w_state_nxt;
   end

   // NOTE: the default assignment first keeps every path driven, so no latch is inferred.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (wstart) w_state_nxt = w_divz_in ? ST_DONE : ST_RUN;
         ST_RUN:  if (r_count == CW'(N - 1)) w_state_nxt = ST_DONE;
         ST_DONE: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         r_count <= '0;
         r_p     <= '0;
         r_q     <= '0;
         r_div   <= '0;
         r_quot  <= '0;
         r_rem   <= '0;
         r_divz  <= 1'b0;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (wstart) begin
                  r_divz  <= w_divz_in;
                  r_count <= '0;
                  r_div   <= w_dvs_mag;
                  if (w_divz_in) begin
                     r_q     <= '1;
                     r_p     <= {1'b0, bdividend};
                     r_neg_q <= 1'b0;
                     r_neg_r <= 1'b0;
                  end else begin
                     r_q     <= w_dvd_mag;
                     r_p     <= '0;
                     r_neg_q <= w_dvd_neg ^ w_dvs_neg;
                     r_neg_r <= w_dvd_neg;
                  end
               end
            end
            ST_RUN: begin
               r_count <= r_count + 1'b1;
               r_q     <= {r_q[N-2:0], ~w_borrow};
               r_p     <= w_borrow ? w_p_sh : w_t;
            end
            ST_DONE: begin
               r_quot <= w_quot_fin;
               r_rem  <= w_rem_fin;
            end
            default: ;
         endcase
      end
   end

   assign wbusy = (r_state == ST_RUN);
   assign wdone = (r_state == ST_DONE);
   assign bquot = wdone ? w_quot_fin : r_quot;
   assign brem  = wdone ? w_rem_fin  : r_rem;
   assign wdivz = r_divz;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (N=8) against an arithmetic reference model.
// Signed scenarios are exercised when JDIV_SIGNED_EN is defined.
module tb_seq_divider;

   localparam int N = 8;

   logic         wclk = 1'b0;
   logic         wrst_n;
   logic         wstart;
   logic [N-1:0] bdividend;
   logic [N-1:0] bdivisor;
   logic         wbusy;
   logic         wdone;
   logic [N-1:0] bquot;
   logic [N-1:0] brem;
   logic         wdivz;
`ifdef JDIV_SIGNED_EN
   logic         wsigned;
`endif

   int checks = 0;
   int errors = 0;

   always #5 wclk = ~wclk;

   seq_divider #(.N(N)) dut (
      .wclk     (wclk),
      .wrst_n   (wrst_n),
      .wstart   (wstart),
`ifdef JDIV_SIGNED_EN
      .wsigned  (wsigned),
`endif
      .bdividend(bdividend),
      .bdivisor (bdivisor),
      .wbusy    (wbusy),
      .wdone    (wdone),
      .bquot    (bquot),
      .brem     (brem),
      .wdivz    (wdivz)
   );

   // Reference: plain integer division; truncation toward zero in signed mode.
   function automatic void ref_div(input logic [N-1:0] a, input logic [N-1:0] b, input logic s,
                                   output logic [N-1:0] q, output logic [N-1:0] r, output logic z);
      int sa, sb;
      z = (b == 0);
      if (z) begin
         q = '1;
         r = a;
      end else if (s) begin
         sa = $signed(a);
         sb = $signed(b);
         q  = N'(sa / sb);
         r  = N'(sa % sb);
      end else begin
         q = a / b;
         r = a % b;
      end
   endfunction

   // Issue one operation and observe it; comparisons are left to the callers.
   task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                         output logic [N-1:0] q, output logic [N-1:0] r, output logic z,
                         output int done_at, output int busy_cnt);
      bdividend = a;
      bdivisor  = b;
      wstart    = 1'b1;
      done_at   = -1;
      busy_cnt  = 0;
      q = '0; r = '0; z = 1'b0;
      for (int c = 1; c <= N + 6; c++) begin
         @(posedge wclk); #1;
         if (c == 1) begin
            wstart    = 1'b0;
            bdividend = N'($urandom);
            bdivisor  = N'($urandom);
         end
         if (wbusy) busy_cnt++;
         if (wdone && done_at < 0) begin
            done_at = c;
            q = bquot; r = brem; z = wdivz;
         end
      end
   endtask

   task automatic check_op(input string name, input logic [N-1:0] a, input logic [N-1:0] b,
                           input logic s);
      logic [N-1:0] q, r, eq, er;
      logic z, ez;
      int done_at, busy_cnt, exp_done, exp_busy;
      run_op(a, b, q, r, z, done_at, busy_cnt);
      ref_div(a, b, s, eq, er, ez);
      exp_done = (b == 0) ? 1 : N + 1;
      exp_busy = (b == 0) ? 0 : N;
      checks++;
      if ({q, r, z} !== {eq, er, ez}) begin
         errors++;
         $display("FAIL %s result %0d/%0d: got q=%0d r=%0d z=%0d expected q=%0d r=%0d z=%0d",
                  name, a, b, q, r, z, eq, er, ez);
      end
      checks++;
      if (done_at != exp_done || busy_cnt != exp_busy) begin
         errors++;
         $display("FAIL %s timing %0d/%0d: got done_at=%0d busy=%0d expected done_at=%0d busy=%0d",
                  name, a, b, done_at, busy_cnt, exp_done, exp_busy);
      end
      checks++;
      if ({bquot, brem, wdivz} !== {eq, er, ez}) begin
         errors++;
         $display("FAIL %s hold %0d/%0d: got q=%0d r=%0d z=%0d expected q=%0d r=%0d z=%0d",
                  name, a, b, bquot, brem, wdivz, eq, er, ez);
      end
   endtask

   task automatic test_reset();
      wrst_n = 1'b0; wstart = 1'b0; bdividend = '0; bdivisor = '0;
`ifdef JDIV_SIGNED_EN
      wsigned = 1'b0;
`endif
      repeat (3) @(posedge wclk);
      #1;
      checks++;
      if ({wbusy, wdone, bquot, brem, wdivz} !== '0) begin
         errors++;
         $display("FAIL reset_state: got busy=%0d done=%0d q=%0d r=%0d z=%0d expected all 0",
                  wbusy, wdone, bquot, brem, wdivz);
      end
      wrst_n = 1'b1;
      @(posedge wclk); #1;
   endtask

   task automatic test_directed();
      logic [N-1:0] tbl_a [5] = '{8'd100, 8'd3,  8'd255, 8'd255, 8'd5};
      logic [N-1:0] tbl_b [5] = '{8'd7,   8'd10, 8'd1,   8'd255, 8'd0};
      for (int i = 0; i < 5; i++) check_op("directed", tbl_a[i], tbl_b[i], 1'b0);
   endtask

   task automatic test_random();
      logic [N-1:0] a, b;
      for (int i = 0; i < 40; i++) begin
         a = N'($urandom);
         case ($urandom_range(0, 7))
            0:       b = '0;
            1:       b = 8'd1;
            2:       b = N'($urandom_range(2, 15));
            default: b = N'($urandom);
         endcase
         check_op("random", a, b, 1'b0);
      end
   endtask

   task automatic test_ignore_start();
      int done_at = -1, ndone = 0;
      logic [N-1:0] q = '0, r = '0;
      bdividend = 8'd200; bdivisor = 8'd3; wstart = 1'b1;
      for (int c = 1; c <= N + 12; c++) begin
         @(posedge wclk); #1;
         if (c == 1) wstart = 1'b0;
         if (c == 4) begin wstart = 1'b1; bdividend = 8'd9; bdivisor = 8'd9; end
         if (c == 5) wstart = 1'b0;
         if (wdone) begin
            ndone++;
            if (done_at < 0) begin done_at = c; q = bquot; r = brem; end
         end
      end
      checks++;
      if (ndone != 1 || done_at != N + 1 || q !== 8'd66 || r !== 8'd2) begin
         errors++;
         $display("FAIL ignore_start: got dones=%0d at=%0d q=%0d r=%0d expected dones=1 at=%0d q=66 r=2",
                  ndone, done_at, q, r, N + 1);
      end
   endtask

   task automatic test_reset_abort();
      int ndone = 0;
      bdividend = 8'd100; bdivisor = 8'd7; wstart = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         @(posedge wclk); #1;
         if (c == 1) wstart = 1'b0;
      end
      wrst_n = 1'b0;
      #1;
      checks++;
      if ({wbusy, wdone, bquot, brem, wdivz} !== '0) begin
         errors++;
         $display("FAIL reset_abort: got busy=%0d done=%0d q=%0d r=%0d z=%0d expected all 0",
                  wbusy, wdone, bquot, brem, wdivz);
      end
      @(posedge wclk); @(posedge wclk); #1;
      wrst_n = 1'b1;
      for (int c = 0; c < N + 6; c++) begin
         @(posedge wclk); #1;
         if (wdone) ndone++;
      end
      checks++;
      if (ndone != 0) begin
         errors++;
         $display("FAIL abort_no_done: got %0d done pulses expected 0", ndone);
      end
      check_op("after_abort", 8'd50, 8'd5, 1'b0);
   endtask

   task automatic test_back_to_back();
      int done_cycles[$];
      logic [N-1:0] eq, er;
      logic ez;
      ref_div(8'd100, 8'd7, 1'b0, eq, er, ez);
      bdividend = 8'd100; bdivisor = 8'd7; wstart = 1'b1;
      for (int c = 1; c <= 35; c++) begin
         @(posedge wclk); #1;
         if (wdone) begin
            done_cycles.push_back(c);
            checks++;
            if ({bquot, brem, wdivz} !== {eq, er, ez}) begin
               errors++;
               $display("FAIL b2b_result: got q=%0d r=%0d z=%0d expected q=%0d r=%0d z=%0d",
                        bquot, brem, wdivz, eq, er, ez);
            end
         end
      end
      wstart = 1'b0;
      repeat (N + 4) @(posedge wclk);
      #1;
      checks++;
      if (done_cycles.size() != 3) begin
         errors++;
         $display("FAIL b2b_count: got %0d done pulses expected 3", done_cycles.size());
      end
      foreach (done_cycles[i]) begin
         checks++;
         if (done_cycles[i] != (N + 1) + i * (N + 2)) begin
            errors++;
            $display("FAIL b2b_spacing: pulse %0d got cycle %0d expected %0d",
                     i, done_cycles[i], (N + 1) + i * (N + 2));
         end
      end
   endtask

`ifdef JDIV_SIGNED_EN
   task automatic test_signed();
      logic [N-1:0] tbl_a [4] = '{8'hF9, 8'd7,  8'h80, 8'hFB};
      logic [N-1:0] tbl_b [4] = '{8'd2,  8'hFE, 8'hFF, 8'd0};
      wsigned = 1'b1;
      for (int i = 0; i < 4; i++) check_op("signed", tbl_a[i], tbl_b[i], 1'b1);
      for (int i = 0; i < 20; i++) check_op("signed_rand", N'($urandom), N'($urandom), 1'b1);
      wsigned = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_ignore_start();
      test_reset_abort();
      test_back_to_back();
`ifdef JDIV_SIGNED_EN
      test_signed();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
